// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner and the hex display it feeds.
// Key codes are {row_idx, col_idx}; hexs holds four 4-bit digits, digit 3 in the top nibble.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  localparam int ROW_W  = 2;
  localparam int COL_W  = 2;
  localparam int CODE_W = ROW_W + COL_W;
  localparam int CNT_W  = 8;

  localparam int DIGITS  = 4;
  localparam int DIGIT_W = 4;
  localparam int HEXS_W  = DIGITS * DIGIT_W;

  typedef struct packed {
    logic             hit;
    logic [COL_W-1:0] idx;
  } col_hit_t;

  // A key counts only when exactly one column is pulled low; anything else is "no key".
  function automatic col_hit_t find_col(input logic [3:0] c);
    col_hit_t r;
    r.hit = 1'b1;
    case (c)
      4'b1110: r.idx = 2'd0;
      4'b1101: r.idx = 2'd1;
      4'b1011: r.idx = 2'd2;
      4'b0111: r.idx = 2'd3;
      default: begin
        r.hit = 1'b0;
        r.idx = 2'd0;
      end
    endcase
    return r;
  endfunction

  function automatic logic [3:0] row_drive(input logic [ROW_W-1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/scan_tick.sv
// Free-running divider producing a one-cycle tick every DIV clock cycles.
module scan_tick #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: row rotation, press/release debounce, and a
// valid/ack key register that also shifts accepted codes into hexs.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        col,
  output logic [3:0]        row,
  input  logic              key_ack,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code,
  output logic              key_down,
  output logic              overrun,
  output logic [HEXS_W-1:0] hexs
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  state_t             state, state_next;
  logic [3:0]         col_m, col_s;
  logic [ROW_W-1:0]   row_idx, row_idx_next;
  logic [COL_W-1:0]   col_idx, col_idx_next;
  logic [CNT_W-1:0]   db_cnt, db_cnt_next, db_cnt_inc;
  logic               key_down_next;
  logic               accept;
  logic               tick;
  col_hit_t           hit;
  logic [CODE_W-1:0]  code;

  scan_tick #(.DIV(SCAN_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign hit        = find_col(col_s);
  assign db_cnt_inc = (db_cnt == LAST) ? LAST : db_cnt + 1'b1;
  assign code       = {row_idx, col_idx};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_m    <= 4'hF;
      col_s    <= 4'hF;
      state    <= SCAN;
      row_idx  <= '0;
      row      <= 4'b1110;
      col_idx  <= '0;
      db_cnt   <= '0;
      key_down <= 1'b0;
    end else begin
      col_m    <= col;
      col_s    <= col_m;
      state    <= state_next;
      row_idx  <= row_idx_next;
      row      <= row_drive(row_idx_next);
      col_idx  <= col_idx_next;
      db_cnt   <= db_cnt_next;
      key_down <= key_down_next;
    end
  end

  // The row only moves while hunting for a key; once a column answers it stays
  // frozen until the key has been debounced away again.
  always_comb begin
    state_next    = state;
    row_idx_next  = row_idx;
    col_idx_next  = col_idx;
    db_cnt_next   = db_cnt;
    key_down_next = key_down;
    accept        = 1'b0;
    if (tick) begin
      case (state)
        SCAN: begin
          if (hit.hit) begin
            col_idx_next = hit.idx;
            db_cnt_next  = '0;
            state_next   = PRESS_DB;
          end else begin
            row_idx_next = row_idx + 1'b1;
          end
        end
        PRESS_DB: begin
          if (hit.hit && (hit.idx == col_idx)) begin
            db_cnt_next = db_cnt_inc;
            if (db_cnt_inc == LAST) begin
              accept        = 1'b1;
              key_down_next = 1'b1;
              state_next    = HELD;
            end
          end else begin
            state_next   = SCAN;
            row_idx_next = row_idx + 1'b1;
          end
        end
        HELD: begin
          if (col_s == 4'hF) begin
            db_cnt_next = '0;
            state_next  = RELEASE_DB;
          end
        end
        RELEASE_DB: begin
          if (col_s == 4'hF) begin
            db_cnt_next = db_cnt_inc;
            if (db_cnt_inc == LAST) begin
              key_down_next = 1'b0;
              state_next    = SCAN;
              row_idx_next  = row_idx + 1'b1;
            end
          end else begin
            state_next = HELD;
          end
        end
      endcase
    end
  end

  // A new key always wins over an ack in the same cycle, so valid stays up.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      overrun   <= 1'b0;
      hexs      <= '0;
    end else if (accept) begin
      key_valid <= 1'b1;
      key_code  <= code;
      hexs      <= {hexs[HEXS_W-DIGIT_W-1:0], code};
      if (key_valid && !key_ack) begin
        overrun <= 1'b1;
      end
    end else if (key_valid && key_ack) begin
      key_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_TICKS=3 and a
// behavioural 4x4 key matrix driving col from row.
module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  col;
  logic [3:0]  row;
  logic        key_ack = 1'b0;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_down;
  logic        overrun;
  logic [15:0] hexs;
  logic [15:0] pressed = '0;

  int checks = 0;
  int errors = 0;

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_TICKS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .col       (col),
    .row       (row),
    .key_ack   (key_ack),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_down  (key_down),
    .overrun   (overrun),
    .hexs      (hexs)
  );

  always #5 clk = ~clk;

  // Key at bit r*4+c shorts row r to column c.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !row[r]) col[c] = 1'b0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset;
    rst = 1'b0;
    key_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_cond(input int sel, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk);
      #1;
      if ((sel == 0 && key_valid === 1'b1) || (sel == 1 && key_down === 1'b1) ||
          (sel == 2 && key_down === 1'b0) || (sel == 3 && row === 4'b1110)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    pressed = '0;
    rst = 1'b0;
    step(3);
    checks++;
    if ({key_valid, key_down, overrun} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL rst_flags: got %b expected 000", {key_valid, key_down, overrun});
    end
    checks++;
    if (key_code !== 4'h0) begin
      errors++;
      $display("[TB] FAIL rst_code: got %h expected 0", key_code);
    end
    checks++;
    if (hexs !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL rst_hexs: got %h expected 0000", hexs);
    end
    checks++;
    if (row !== 4'b1110) begin
      errors++;
      $display("[TB] FAIL rst_row: got %b expected 1110", row);
    end
  endtask

  task automatic test_single_press;
    bit ok;
    pressed = 16'd1 << 9;
    do_reset;
    step(19);
    checks++;
    if (key_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL s1_early: key_valid got %b expected 0", key_valid);
    end
    step(1);
    checks++;
    if (key_valid !== 1'b1 || key_code !== 4'h9) begin
      errors++;
      $display("[TB] FAIL s1_accept: valid/code got %b/%h expected 1/9", key_valid, key_code);
    end
    checks++;
    if (key_down !== 1'b1 || hexs !== 16'h0009 || row !== 4'b1011) begin
      errors++;
      $display("[TB] FAIL s1_state: down/hexs/row got %b/%h/%b expected 1/0009/1011",
               key_down, hexs, row);
    end
    key_ack = 1'b1;
    step(1);
    key_ack = 1'b0;
    checks++;
    if (key_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL s1_ack: key_valid got %b expected 0", key_valid);
    end
    pressed = '0;
    wait_cond(2, 100, ok);
    checks++;
    if (!ok || row !== 4'b0111) begin
      errors++;
      $display("[TB] FAIL s1_release: key_down/row got %b/%b expected 0/0111", key_down, row);
    end
  endtask

  task automatic test_bounce;
    int seen;
    pressed = 16'd1 << 9;
    do_reset;
    step(16);
    pressed = '0;
    step(4);
    checks++;
    if (key_valid !== 1'b0 || key_down !== 1'b0 || row !== 4'b0111) begin
      errors++;
      $display("[TB] FAIL s2_abort: valid/down/row got %b/%b/%b expected 0/0/0111",
               key_valid, key_down, row);
    end
    pressed = 16'd1 << 9;
    seen = 0;
    for (int i = 0; i < 23; i++) begin
      step(1);
      if (key_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("[TB] FAIL s2_premature: valid cycles got %0d expected 0", seen);
    end
    step(1);
    checks++;
    if (key_valid !== 1'b1 || key_code !== 4'h9) begin
      errors++;
      $display("[TB] FAIL s2_accept: valid/code got %b/%h expected 1/9", key_valid, key_code);
    end
    key_ack = 1'b1;
    step(1);
    key_ack = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (key_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0 || key_down !== 1'b1) begin
      errors++;
      $display("[TB] FAIL s2_single: extra valid cycles/down got %0d/%b expected 0/1", seen, key_down);
    end
    pressed = '0;
  endtask

  task automatic test_sequence;
    bit ok;
    pressed = '0;
    do_reset;
    for (int k = 1; k <= 4; k++) begin
      pressed = 16'd1 << k;
      wait_cond(0, 200, ok);
      checks++;
      if (!ok || key_code !== 4'(k)) begin
        errors++;
        $display("[TB] FAIL s3_code%0d: got %h expected %h", k, key_code, 4'(k));
      end
      key_ack = 1'b1;
      step(1);
      key_ack = 1'b0;
      pressed = '0;
      wait_cond(2, 200, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("[TB] FAIL s3_release%0d: key_down got %b expected 0", k, key_down);
      end
    end
    checks++;
    if (hexs !== 16'h1234 || overrun !== 1'b0 || key_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL s3_final: hexs/overrun/valid got %h/%b/%b expected 1234/0/0",
               hexs, overrun, key_valid);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    pressed = '0;
    do_reset;
    pressed = 16'd1 << 5;
    wait_cond(0, 200, ok);
    checks++;
    if (!ok || key_code !== 4'h5) begin
      errors++;
      $display("[TB] FAIL s4_first: got %h expected 5", key_code);
    end
    pressed = '0;
    wait_cond(2, 200, ok);
    pressed = 16'd1 << 6;
    wait_cond(1, 200, ok);
    checks++;
    if (!ok || key_code !== 4'h6 || overrun !== 1'b1 || key_valid !== 1'b1 || hexs !== 16'h0056) begin
      errors++;
      $display("[TB] FAIL s4_overrun: code/overrun/valid/hexs got %h/%b/%b/%h expected 6/1/1/0056",
               key_code, overrun, key_valid, hexs);
    end
    pressed = '0;
    wait_cond(2, 200, ok);
    pressed = 16'd1 << 3;
    wait_cond(3, 200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL s4_row0: row got %b expected 1110", row);
    end
    step(11);
    checks++;
    if (key_code !== 4'h6) begin
      errors++;
      $display("[TB] FAIL s4_pre_accept: code got %h expected 6", key_code);
    end
    key_ack = 1'b1;
    step(1);
    key_ack = 1'b0;
    checks++;
    if (key_valid !== 1'b1 || key_code !== 4'h3 || overrun !== 1'b1 || hexs !== 16'h0563) begin
      errors++;
      $display("[TB] FAIL s4_ack_accept: valid/code/overrun/hexs got %b/%h/%b/%h expected 1/3/1/0563",
               key_valid, key_code, overrun, hexs);
    end
    step(1);
    checks++;
    if (key_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL s4_valid_hold: key_valid got %b expected 1", key_valid);
    end
    pressed = '0;
  endtask

  task automatic test_multi_key;
    logic [3:0] exp_rows [4];
    int seen;
    exp_rows = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    pressed = 16'h0003;
    do_reset;
    step(3);
    checks++;
    if (row !== 4'b1110) begin
      errors++;
      $display("[TB] FAIL s5_row_start: got %b expected 1110", row);
    end
    seen = 0;
    step(1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (row !== exp_rows[i]) begin
        errors++;
        $display("[TB] FAIL s5_rotate%0d: got %b expected %b", i, row, exp_rows[i]);
      end
      for (int j = 0; j < 4; j++) begin
        if (key_valid !== 1'b0 || key_down !== 1'b0) seen++;
        step(1);
      end
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("[TB] FAIL s5_no_accept: cycles with valid/down got %0d expected 0", seen);
    end
    pressed = '0;
  endtask

  task automatic test_reset_mid_debounce;
    pressed = 16'd1 << 6;
    do_reset;
    step(13);
    checks++;
    if (row !== 4'b1101 || key_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL s6_pre: row/valid got %b/%b expected 1101/0", row, key_valid);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (row !== 4'b1110 || {key_valid, key_down, overrun} !== 3'b000 || key_code !== 4'h0 ||
        hexs !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL s6_in_reset: row/flags/code/hexs got %b/%b/%h/%h expected 1110/000/0/0000",
               row, {key_valid, key_down, overrun}, key_code, hexs);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step(15);
    checks++;
    if (key_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL s6_early: key_valid got %b expected 0", key_valid);
    end
    step(1);
    checks++;
    if (key_valid !== 1'b1 || key_code !== 4'h6 || hexs !== 16'h0006) begin
      errors++;
      $display("[TB] FAIL s6_fresh: valid/code/hexs got %b/%h/%h expected 1/6/0006",
               key_valid, key_code, hexs);
    end
    pressed = '0;
  endtask

  initial begin
    test_reset;
    test_single_press;
    test_bounce;
    test_sequence;
    test_back_to_back;
    test_multi_key;
    test_reset_mid_debounce;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
